// File: rtl/pong_pkg.sv
// Shared constants, button indices and hold FSM encoding
// for the pong start menu and game logic.
package pong_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_10MS =
    CLK_FREQ_HZ / 100;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_ENTER = 2;
  localparam int unsigned BTN_AUX   = 3;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_e;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic bit cnt_fits(
    input int unsigned w,
    input int unsigned v
  );
    if (w >= 32) return 1'b1;
    return v < (32'd1 << w);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce, press edge.
// Hold auto-repeat is built only with MENU_BTN_AUTOREPEAT_EN.
module btn_debounce_ch
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES =
    DEBOUNCE_CYCLES_10MS,
`ifdef MENU_BTN_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 20_000_000,
`endif
  parameter int unsigned CNT_W = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic press_nxt
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rise;

  // two-stage synchroniser for the asynchronous pad
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // accept a change only after it has persisted long enough
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise = stable_d & ~stable_q;

`ifdef MENU_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST =
    CNT_W'(REPEAT_PERIOD - 1);

  hold_state_e      state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rpt;

  // hold FSM: delay, then periodic repeat while held
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt     = 1'b0;
    if (!stable_d) begin
      state_d = HOLD_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        HOLD_IDLE: begin
          if (rise) begin
            state_d = HOLD_DELAY;
            rcnt_d  = '0;
          end
        end
        HOLD_DELAY: begin
          if (rcnt_q == RD_LAST) begin
            rpt     = 1'b1;
            state_d = HOLD_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (rcnt_q == RP_LAST) begin
            rpt    = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = HOLD_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // hold FSM state and repeat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign press_d = rise | rpt;
`else
  assign press_d = rise;
`endif

  // debounce state and registered press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level     = stable_q;
  assign press     = press_q;
  assign press_nxt = press_d;

endmodule

// File: rtl/menu_button_conditioner.sv
// Clean level and one-clk press pulse per menu button.
// Define MENU_BTN_AUTOREPEAT_EN to add hold auto-repeat.
module menu_button_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES =
    DEBOUNCE_CYCLES_10MS,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               btn_any
);

  if (!cnt_fits(CNT_W, max3(DEBOUNCE_CYCLES,
      REPEAT_DELAY, REPEAT_PERIOD))) begin : g_cnt_w_bad
    $error("CNT_W too small for configured counts");
  end

  logic [NUM_BTN-1:0] press_nxt;
  logic               any_q, any_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef MENU_BTN_AUTOREPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw       (btn_raw[i]),
      .level     (btn_level[i]),
      .press     (btn_press[i]),
      .press_nxt (press_nxt[i])
    );
  end

  // any-press aligned with the per-channel pulse registers
  always_comb begin
    any_d = |press_nxt;
  end

  // btn_any register
  always_ff @(posedge clk) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign btn_any = any_q;

endmodule
